// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: register file with one write port and two registered read ports.
// Entry 0 always reads as zero. A read of the address being written returns the new data.
module reg_file_2r1w #(
    parameter int SIZE   = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [SIZE-1:0]   din_i,
    input  logic              rd_en_a_i,
    input  logic [ADDR_W-1:0] rd_addr_a_i,
    output logic [SIZE-1:0]   dout_a_o,
    output logic              valid_a_o,
    input  logic              rd_en_b_i,
    input  logic [ADDR_W-1:0] rd_addr_b_i,
    output logic [SIZE-1:0]   dout_b_o,
    output logic              valid_b_o
);
    typedef enum logic {IDLE, VALID} vstate_e;

    logic [SIZE-1:0] mem_q [DEPTH];
    logic [SIZE-1:0] dout_a_q, dout_a_d, dout_b_q, dout_b_d;
    logic [SIZE-1:0] rdata_a, rdata_b;
    vstate_e         va_q, va_d, vb_q, vb_d;
    logic            wr_ok, ok_a, ok_b;

    // One extra bit lets DEPTH == 2**ADDR_W be compared without overflow.
    always_comb begin
        wr_ok    = wr_en_i && wr_addr_i != '0 && {1'b0, wr_addr_i} < (ADDR_W+1)'(DEPTH);
        ok_a     = rd_addr_a_i != '0 && {1'b0, rd_addr_a_i} < (ADDR_W+1)'(DEPTH);
        ok_b     = rd_addr_b_i != '0 && {1'b0, rd_addr_b_i} < (ADDR_W+1)'(DEPTH);
        rdata_a  = !ok_a ? '0 : (wr_en_i && wr_addr_i == rd_addr_a_i) ? din_i : mem_q[rd_addr_a_i];
        rdata_b  = !ok_b ? '0 : (wr_en_i && wr_addr_i == rd_addr_b_i) ? din_i : mem_q[rd_addr_b_i];
        dout_a_d = rd_en_a_i ? rdata_a : dout_a_q;
        dout_b_d = rd_en_b_i ? rdata_b : dout_b_q;
        va_d     = rd_en_a_i ? VALID : IDLE;
        vb_d     = rd_en_b_i ? VALID : IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_ok) begin
            mem_q[wr_addr_i] <= din_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dout_a_q <= '0;
            dout_b_q <= '0;
            va_q     <= IDLE;
            vb_q     <= IDLE;
        end else begin
            dout_a_q <= dout_a_d;
            dout_b_q <= dout_b_d;
            va_q     <= va_d;
            vb_q     <= vb_d;
        end
    end

    assign dout_a_o  = dout_a_q;
    assign dout_b_o  = dout_b_q;
    assign valid_a_o = va_q == VALID;
    assign valid_b_o = vb_q == VALID;
endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb_reg_file_2r1w: directed scoreboard bench for reg_file_2r1w.
// Drives a full-depth (8) and a reduced-depth (6) instance with the same stimulus.
module tb_reg_file_2r1w;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       we = 1'b0, ea = 1'b0, eb = 1'b0;
    logic [2:0] wa = '0, aa = '0, ab = '0;
    logic [7:0] din = '0;
    logic [7:0] da8, db8, da6, db6;
    logic       va8, vb8, va6, vb6;

    int checks = 0;
    int errors = 0;

    logic [7:0] m8 [8];
    logic [7:0] m6 [8];
    logic [7:0] qa8[$], qb8[$], qa6[$], qb6[$];
    logic [7:0] ha8, hb8, ha6, hb6;

    always #5 clk = ~clk;

    reg_file_2r1w #(.SIZE(8), .DEPTH(8), .ADDR_W(3)) u8 (
        .clk_i(clk), .rst_i(rst), .wr_en_i(we), .wr_addr_i(wa), .din_i(din),
        .rd_en_a_i(ea), .rd_addr_a_i(aa), .dout_a_o(da8), .valid_a_o(va8),
        .rd_en_b_i(eb), .rd_addr_b_i(ab), .dout_b_o(db8), .valid_b_o(vb8)
    );

    reg_file_2r1w #(.SIZE(8), .DEPTH(6), .ADDR_W(3)) u6 (
        .clk_i(clk), .rst_i(rst), .wr_en_i(we), .wr_addr_i(wa), .din_i(din),
        .rd_en_a_i(ea), .rd_addr_a_i(aa), .dout_a_o(da6), .valid_a_o(va6),
        .rd_en_b_i(eb), .rd_addr_b_i(ab), .dout_b_o(db6), .valid_b_o(vb6)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] expect_rd(input logic [7:0] m [8], input int depth, input logic [2:0] a);
        if (a == 0 || int'(a) >= depth) return 8'h00;
        if (we && wa == a) return din;
        return m[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 8; i++) begin
            m8[i] = '0;
            m6[i] = '0;
        end
        qa8.delete(); qb8.delete(); qa6.delete(); qb6.delete();
        ha8 = '0; hb8 = '0; ha6 = '0; hb6 = '0;
    endtask

    // One clock: drive, predict, let the edge happen, then compare.
    task automatic step(input string tag, input logic w, input logic [2:0] wadr, input logic [7:0] d,
                        input logic ra, input logic [2:0] radr_a, input logic rb, input logic [2:0] radr_b);
        @(negedge clk);
        we = w; wa = wadr; din = d; ea = ra; aa = radr_a; eb = rb; ab = radr_b;
        if (ra) begin
            qa8.push_back(expect_rd(m8, 8, aa));
            qa6.push_back(expect_rd(m6, 6, aa));
        end
        if (rb) begin
            qb8.push_back(expect_rd(m8, 8, ab));
            qb6.push_back(expect_rd(m6, 6, ab));
        end
        @(posedge clk);
        if (w && wadr != 0) m8[wadr] = d;
        if (w && wadr != 0 && wadr < 6) m6[wadr] = d;
        #1;
        chk({tag, " valid_a8"}, {7'd0, va8}, {7'd0, ra});
        chk({tag, " valid_b8"}, {7'd0, vb8}, {7'd0, rb});
        chk({tag, " valid_a6"}, {7'd0, va6}, {7'd0, ra});
        chk({tag, " valid_b6"}, {7'd0, vb6}, {7'd0, rb});
        if (ra && qa8.size() > 0) ha8 = qa8.pop_front();
        if (rb && qb8.size() > 0) hb8 = qb8.pop_front();
        if (ra && qa6.size() > 0) ha6 = qa6.pop_front();
        if (rb && qb6.size() > 0) hb6 = qb6.pop_front();
        chk({tag, " dout_a8"}, da8, ha8);
        chk({tag, " dout_b8"}, db8, hb8);
        chk({tag, " dout_a6"}, da6, ha6);
        chk({tag, " dout_b6"}, db6, hb6);
    endtask

    initial begin
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        chk("rst dout_a8", da8, 8'h00);
        chk("rst valid_a8", {7'd0, va8}, 8'h00);
        chk("rst dout_b6", db6, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) step("t1 zero read", 1'b0, 3'd0, 8'h00, 1'b1, 3'(i), 1'b1, 3'(7 - i));
        step("t1 idle", 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0);

        step("t2 write3", 1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 1'b0, 3'd0);
        step("t2 read3", 1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b0, 3'd0);
        step("t2 hold", 1'b0, 3'd0, 8'h00, 1'b0, 3'd1, 1'b0, 3'd3);

        step("t3 bypass5", 1'b1, 3'd5, 8'h3C, 1'b1, 3'd5, 1'b1, 3'd5);
        step("t3 reread5", 1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 1'b1, 3'd3);

        step("t4 write0", 1'b1, 3'd0, 8'hFF, 1'b0, 3'd0, 1'b0, 3'd0);
        step("t4 read0", 1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 1'b1, 3'd0);
        step("t4 wr+rd0", 1'b1, 3'd0, 8'hFF, 1'b1, 3'd0, 1'b1, 3'd0);

        step("t5 write6", 1'b1, 3'd6, 8'h77, 1'b0, 3'd0, 1'b0, 3'd0);
        step("t5 read6", 1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 1'b1, 3'd5);
        step("t5 wr7 rd7", 1'b1, 3'd7, 8'h5A, 1'b1, 3'd7, 1'b1, 3'd6);
        step("t5 read7", 1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 1'b1, 3'd5);

        step("t6 inflight", 1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b1, 3'd5);
        #2;
        rst = 1'b1;
        #1;
        clear_model();
        chk("t6 async valid_a8", {7'd0, va8}, 8'h00);
        chk("t6 async dout_a8", da8, 8'h00);
        chk("t6 async valid_b6", {7'd0, vb6}, 8'h00);
        chk("t6 async dout_b6", db6, 8'h00);
        @(negedge clk);
        ea = 1'b1; aa = 3'd3;
        @(posedge clk);
        #1;
        chk("t6 rst read valid_a8", {7'd0, va8}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        step("t6 reread3", 1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b1, 3'd5);
        step("t6 idle", 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
